// File: rtl/ctrl_burst_act.sv
// Purpose: tracks open rows per bank, issues PRECHARGE/ACTIVATE strobes under tRP/tRRD/tFAW and forwards requests to CAS.
// Latency: row hit strobes 2 clocks after accept, closed-bank ACTIVATE 3 clocks after accept, row conflict adds PRE plus tRP.
// Backpressure: one request in flight; req_ready is high only while idle, so a stalled timing window holds off upstream.
module ctrl_burst_act #(
    parameter int          BANKS  = 16,
    parameter int          BANK_W = 4,
    parameter int          ROW_W  = 17,
    parameter int          T_RRD  = 4,
    parameter int          T_FAW  = 20,
    parameter int          T_RP   = 12,
    parameter logic [2:0]  RDA_R  = 3'd2,
    parameter logic [2:0]  WRA_R  = 3'd4
) (
    input  logic              CK_t,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic [2:0]        req_cmd,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    output logic              req_ready,
    output logic              pre_rdy,
    output logic              act_rdy,
    output logic              no_act_rdy,
    output logic [2:0]        act_rw,
    output logic [BANK_W-1:0] act_bank,
    output logic [ROW_W-1:0]  act_row
);

    localparam int RRD_W = $clog2(T_RRD + 1);
    localparam int FAW_W = $clog2(T_FAW + 1);
    localparam int RP_W  = $clog2(T_RP + 1);
    // Clocks from the WAIT decision to the ACTIVATE strobe (WAIT->ISSUE, ISSUE->strobe).
    // Timing checks look ahead by this much so the strobe itself lands exactly on the limit.
    localparam int LOOK  = 2;

    localparam logic [RRD_W-1:0] RRD_MAX  = RRD_W'(T_RRD);
    localparam logic [FAW_W-1:0] FAW_LOAD = FAW_W'(T_FAW);
    localparam logic [RP_W-1:0]  RP_LOAD  = RP_W'(T_RP);

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_DECODE,
        ACT_HIT,
        ACT_PRE,
        ACT_WAIT,
        ACT_ISSUE
    } act_state_t;

    act_state_t         state;
    logic [2:0]         cur_cmd;
    logic [BANK_W-1:0]  cur_bank;
    logic [ROW_W-1:0]   cur_row;
    logic [BANKS-1:0]   bank_open;
    logic [ROW_W-1:0]   open_row [BANKS];
    logic [RP_W-1:0]    trp_cnt  [BANKS];
    logic [RRD_W-1:0]   trrd_cnt;
    logic [FAW_W-1:0]   faw_cnt  [4];

    logic               rp_ok;
    logic               rrd_ok;
    logic               faw_ok;
    logic [2:0]         faw_busy;
    logic [1:0]         faw_sel;
    logic               is_ap;
    logic               row_hit;

    // Timing-window qualification for the captured request, plus row-hit and auto-precharge decode.
    always_comb begin
        rp_ok    = int'(trp_cnt[cur_bank]) <= LOOK;
        rrd_ok   = (int'(trrd_cnt) + LOOK) >= T_RRD;
        faw_busy = 3'd0;
        faw_sel  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            // A slot at 1 reaches 0 on the strobe edge, so it can be reused by this ACTIVATE.
            if (int'(faw_cnt[i]) <= 1) begin
                faw_sel = 2'(i);
            end
            if (int'(faw_cnt[i]) > LOOK) begin
                faw_busy = faw_busy + 3'd1;
            end
        end
        faw_ok  = faw_busy < 3'd4;
        is_ap   = (cur_cmd == RDA_R) || (cur_cmd == WRA_R);
        row_hit = open_row[cur_bank] == cur_row;
    end

    // Request FSM, bank table, timing counters and registered strobes.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ACT_IDLE;
            req_ready  <= 1'b1;
            pre_rdy    <= 1'b0;
            act_rdy    <= 1'b0;
            no_act_rdy <= 1'b0;
            act_rw     <= '0;
            act_bank   <= '0;
            act_row    <= '0;
            cur_cmd    <= '0;
            cur_bank   <= '0;
            cur_row    <= '0;
            bank_open  <= '0;
            trrd_cnt   <= RRD_MAX;
            for (int b = 0; b < BANKS; b++) begin
                open_row[b] <= '0;
                trp_cnt[b]  <= '0;
            end
            for (int f = 0; f < 4; f++) begin
                faw_cnt[f] <= '0;
            end
        end else begin
            pre_rdy    <= 1'b0;
            act_rdy    <= 1'b0;
            no_act_rdy <= 1'b0;

            if (int'(trrd_cnt) < T_RRD) begin
                trrd_cnt <= trrd_cnt + 1'b1;
            end
            for (int b = 0; b < BANKS; b++) begin
                if (trp_cnt[b] != '0) begin
                    trp_cnt[b] <= trp_cnt[b] - 1'b1;
                end
            end
            for (int f = 0; f < 4; f++) begin
                if (faw_cnt[f] != '0) begin
                    faw_cnt[f] <= faw_cnt[f] - 1'b1;
                end
            end

            case (state)
                ACT_IDLE: begin
                    if (req_valid) begin
                        cur_cmd   <= req_cmd;
                        cur_bank  <= req_bank;
                        cur_row   <= req_row;
                        req_ready <= 1'b0;
                        state     <= ACT_DECODE;
                    end
                end
                ACT_DECODE: begin
                    if (bank_open[cur_bank]) begin
                        state <= row_hit ? ACT_HIT : ACT_PRE;
                    end else begin
                        state <= ACT_WAIT;
                    end
                end
                ACT_HIT: begin
                    no_act_rdy <= 1'b1;
                    act_rw     <= cur_cmd;
                    act_bank   <= cur_bank;
                    act_row    <= cur_row;
                    if (is_ap) begin
                        bank_open[cur_bank] <= 1'b0;
                        trp_cnt[cur_bank]   <= RP_LOAD;
                    end
                    req_ready <= 1'b1;
                    state     <= ACT_IDLE;
                end
                ACT_PRE: begin
                    pre_rdy             <= 1'b1;
                    act_rw              <= cur_cmd;
                    act_bank            <= cur_bank;
                    bank_open[cur_bank] <= 1'b0;
                    trp_cnt[cur_bank]   <= RP_LOAD;
                    state               <= ACT_WAIT;
                end
                ACT_WAIT: begin
                    if (rp_ok && rrd_ok && faw_ok) begin
                        state <= ACT_ISSUE;
                    end
                end
                ACT_ISSUE: begin
                    act_rdy             <= 1'b1;
                    act_rw              <= cur_cmd;
                    act_bank            <= cur_bank;
                    act_row             <= cur_row;
                    open_row[cur_bank]  <= cur_row;
                    bank_open[cur_bank] <= ~is_ap;
                    if (is_ap) begin
                        trp_cnt[cur_bank] <= RP_LOAD;
                    end
                    trrd_cnt         <= '0;
                    faw_cnt[faw_sel] <= FAW_LOAD;
                    req_ready        <= 1'b1;
                    state            <= ACT_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= ACT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_burst_act.sv
// Purpose: directed scoreboard bench for ctrl_burst_act (hit/miss/conflict paths, tRP/tRRD/tFAW, reset).
// Latency: expectations carry the strobe cycle where the timing is exact.
// Backpressure: requests are presented only when req_ready is observed high.
module tb_ctrl_burst_act;

    localparam logic [2:0] RD_R  = 3'd1;
    localparam logic [2:0] RDA_R = 3'd2;
    localparam logic [2:0] WR_R  = 3'd3;
    localparam logic [2:0] WRA_R = 3'd4;
    localparam int K_PRE = 0;
    localparam int K_ACT = 1;
    localparam int K_HIT = 2;

    logic        CK_t = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [2:0]  req_cmd;
    logic [3:0]  req_bank;
    logic [16:0] req_row;
    logic        req_ready;
    logic        pre_rdy;
    logic        act_rdy;
    logic        no_act_rdy;
    logic [2:0]  act_rw;
    logic [3:0]  act_bank;
    logic [16:0] act_row;

    typedef struct {
        int          kind;
        logic [2:0]  rw;
        logic [3:0]  bank;
        logic [16:0] row;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   log_cyc[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   acc;
    int   i0;
    exp_t mon_e;
    int   mon_k;

    ctrl_burst_act #(
        .RDA_R (RDA_R),
        .WRA_R (WRA_R)
    ) dut (
        .CK_t       (CK_t),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_bank   (req_bank),
        .req_row    (req_row),
        .req_ready  (req_ready),
        .pre_rdy    (pre_rdy),
        .act_rdy    (act_rdy),
        .no_act_rdy (no_act_rdy),
        .act_rw     (act_rw),
        .act_bank   (act_bank),
        .act_row    (act_row)
    );

    always #5 CK_t = ~CK_t;

    always @(posedge CK_t) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int kind, input logic [2:0] rw, input logic [3:0] bank,
                            input logic [16:0] row, input int c);
        exp_t e;
        e.kind = kind;
        e.rw   = rw;
        e.bank = bank;
        e.row  = row;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] cmd, input logic [3:0] bank, input logic [16:0] row,
                        output int acc_cyc);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge CK_t);
            n++;
        end
        chk("ready_before_send", req_ready, 1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_bank  = bank;
        req_row   = row;
        @(posedge CK_t);
        #1;
        acc_cyc = cyc;
        chk("ready_low_after_accept", req_ready, 0);
        @(negedge CK_t);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge CK_t);
            n++;
        end
        chk(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"},  req_ready, 1);
        chk({tag, "_pre_rdy"},    pre_rdy, 0);
        chk({tag, "_act_rdy"},    act_rdy, 0);
        chk({tag, "_no_act_rdy"}, no_act_rdy, 0);
        chk({tag, "_act_rw"},     act_rw, 0);
        chk({tag, "_act_bank"},   act_bank, 0);
        chk({tag, "_act_row"},    act_row, 0);
    endtask

    // Strobe monitor: pops the scoreboard on each strobe and compares kind, fields and cycle.
    always @(negedge CK_t) begin
        if (reset_n === 1'b1 && (pre_rdy || act_rdy || no_act_rdy)) begin
            chk("strobe_onehot", int'(pre_rdy) + int'(act_rdy) + int'(no_act_rdy), 1);
            mon_k = act_rdy ? K_ACT : (no_act_rdy ? K_HIT : K_PRE);
            log_cyc.push_back(cyc);
            chk("strobe_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("strobe_kind", mon_k, mon_e.kind);
                chk("strobe_rw", act_rw, mon_e.rw);
                chk("strobe_bank", act_bank, mon_e.bank);
                if (mon_e.kind != K_PRE) begin
                    chk("strobe_row", act_row, mon_e.row);
                end
                if (mon_e.cyc >= 0) begin
                    chk("strobe_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_cmd   = '0;
        req_bank  = '0;
        req_row   = '0;
        repeat (3) @(negedge CK_t);
        check_reset("rst");
        reset_n = 1'b1;
        @(negedge CK_t);

        // Closed bank: DECODE, WAIT, ISSUE -> ACTIVATE 3 clocks after accept.
        send(RD_R, 4'd2, 17'h100, acc);
        push_exp(K_ACT, RD_R, 4'd2, 17'h100, acc + 3);
        drain("t1_drain");

        // Same row again: hit 2 clocks after accept, no PRE/ACT.
        send(WR_R, 4'd2, 17'h100, acc);
        push_exp(K_HIT, WR_R, 4'd2, 17'h100, acc + 2);
        drain("t2_drain");

        // Row conflict: PRE 2 clocks after accept, ACT exactly tRP later.
        send(RD_R, 4'd2, 17'h200, acc);
        push_exp(K_PRE, RD_R, 4'd2, 17'h0, acc + 2);
        push_exp(K_ACT, RD_R, 4'd2, 17'h200, acc + 14);
        drain("t3_drain");
        chk("t3_trp_gap", log_cyc[log_cyc.size()-1] - log_cyc[log_cyc.size()-2], 12);

        // Back-to-back closed banks: ACTs spaced exactly tRRD.
        i0 = log_cyc.size();
        send(RD_R, 4'd0, 17'h40, acc);
        push_exp(K_ACT, RD_R, 4'd0, 17'h40, -1);
        send(RD_R, 4'd1, 17'h41, acc);
        push_exp(K_ACT, RD_R, 4'd1, 17'h41, acc + 3);
        drain("t4_drain");
        chk("t4_trrd_gap", log_cyc[i0+1] - log_cyc[i0], 4);

        // Fresh state, five ACTs: four at tRRD spacing, fifth held by tFAW.
        reset_n = 1'b0;
        @(negedge CK_t);
        check_reset("t5_rst");
        reset_n = 1'b1;
        @(negedge CK_t);
        i0 = log_cyc.size();
        for (int i = 0; i < 5; i++) begin
            send(RD_R, 4'(i), 17'h10 + 17'(i), acc);
            push_exp(K_ACT, RD_R, 4'(i), 17'h10 + 17'(i), (i == 0) ? acc + 3 : -1);
        end
        drain("t5_drain");
        chk("t5_gap_1_2", log_cyc[i0+1] - log_cyc[i0], 4);
        chk("t5_gap_2_3", log_cyc[i0+2] - log_cyc[i0+1], 4);
        chk("t5_gap_3_4", log_cyc[i0+3] - log_cyc[i0+2], 4);
        chk("t5_faw_5th", (log_cyc[i0+4] - log_cyc[i0]) >= 20, 1);

        // Auto-precharge hit closes the bank; the next same-row request re-activates after tRP.
        i0 = log_cyc.size();
        send(RDA_R, 4'd0, 17'h10, acc);
        push_exp(K_HIT, RDA_R, 4'd0, 17'h10, acc + 2);
        send(RD_R, 4'd0, 17'h10, acc);
        push_exp(K_ACT, RD_R, 4'd0, 17'h10, -1);
        drain("t6_ap_drain");
        chk("t6_ap_trp", (log_cyc[i0+1] - log_cyc[i0]) >= 12, 1);

        // Reset while waiting out tRP after a PRE: outputs clear at once, no ACT follows.
        send(RD_R, 4'd0, 17'h3ff, acc);
        push_exp(K_PRE, RD_R, 4'd0, 17'h0, acc + 2);
        drain("t6_pre_drain");
        repeat (4) @(negedge CK_t);
        i0 = log_cyc.size();
        reset_n = 1'b0;
        #1;
        check_reset("t6_rst_wait");
        repeat (2) @(negedge CK_t);
        reset_n = 1'b1;
        repeat (20) @(negedge CK_t);
        chk("t6_quiet_after_rst", log_cyc.size(), i0);
        chk("t6_ready_after_rst", req_ready, 1);

        // Bank table was cleared: same request takes the closed path with no PRE.
        send(RD_R, 4'd0, 17'h3ff, acc);
        push_exp(K_ACT, RD_R, 4'd0, 17'h3ff, acc + 3);
        drain("t6_final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
